// File: rtl/rdma_tx_pkt.sv
// RC transmit packetizer: each accepted send request produces a two-beat header (opcode/PKEY/QPN,
// then PSN/length) followed by the payload beats, on a 64-bit valid/ready stream with a last marker.
module rdma_tx_pkt #(
    parameter int unsigned LEN_W    = 16,
    parameter logic [23:0] PSN_INIT = 24'h0,
    parameter logic [15:0] PKEY     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_opcode,
    input  logic [23:0]      req_qpn,
    input  logic [LEN_W-1:0] req_len,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [63:0]      pl_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [63:0]      tx_data,
    output logic             tx_last,
    output logic [23:0]      psn_cur,
    output logic             pkt_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR1    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [23:0]      psn_q, psn_d;
    logic             tx_valid_q, tx_valid_d;
    logic [63:0]      tx_data_q, tx_data_d;
    logic             tx_last_q, tx_last_d;
    logic             pkt_done_q, pkt_done_d;
    logic             slot_free;
    logic [15:0]      len16;

    // The output slot can take a new beat when empty or draining this cycle.
    assign slot_free = !tx_valid_q || tx_ready;
    assign req_ready = (state_q == S_IDLE) && slot_free;
    assign pl_ready  = (state_q == S_PAYLOAD) && slot_free;
    assign len16     = 16'(len_q);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        psn_d      = psn_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        pkt_done_d = tx_valid_q && tx_ready && tx_last_q;
        if (slot_free) tx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    len_d      = req_len;
                    tx_data_d  = {req_opcode, 8'h00, PKEY, 8'h00, req_qpn};
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (slot_free) begin
                    tx_data_d  = {8'h00, psn_q, 16'h0000, len16};
                    tx_valid_d = 1'b1;
                    tx_last_d  = (len_q == '0);
                    psn_d      = psn_q + 24'd1;
                    cnt_d      = len_q;
                    state_d    = (len_q == '0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (pl_valid && slot_free) begin
                    tx_data_d  = pl_data;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (cnt_q == LEN_W'(1));
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            psn_q      <= PSN_INIT;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 64'h0;
            tx_last_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            psn_q      <= psn_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_last  = tx_last_q;
    assign psn_cur  = psn_q;
    assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_rdma_tx_pkt.sv
// Bench for rdma_tx_pkt: scripted and random requests feed a packet-level model that predicts
// every tx beat, PSN and pkt_done; stalls, back-to-back throughput and mid-packet reset are covered.
module tb_rdma_tx_pkt;

    localparam logic [23:0] PSN0 = 24'hFFFFFE;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        psn_chk;
        logic [23:0] psn_after;
    } beat_t;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] qpn;
        logic [15:0] len;
    } req_t;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_opcode;
    logic [23:0] req_qpn;
    logic [15:0] req_len;
    logic        pl_valid, pl_ready;
    logic [63:0] pl_data;
    logic        tx_valid, tx_ready, tx_last, pkt_done;
    logic [63:0] tx_data;
    logic [23:0] psn_cur;

    rdma_tx_pkt #(.LEN_W(16), .PSN_INIT(PSN0), .PKEY(16'hFFFF)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_qpn(req_qpn), .req_len(req_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .psn_cur(psn_cur), .pkt_done(pkt_done)
    );

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    beat_t       exp_q[$];
    logic [63:0] pl_q[$];
    logic [63:0] dir_pl[$];
    req_t        script[$];
    logic [23:0] model_psn;
    bit          rdy_mode;   // 0: tx_ready held high, 1: random
    int          pl_pct;
    bit          pl_en;
    int          hs_cnt, first_hs, last_hs, req_hs_cyc;
    bit          pl_rdy_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a request expands to its full expected beat sequence when it is issued.
    task automatic gen(input req_t r);
        beat_t b;
        logic [63:0] w;
        b = '{data: {r.op, 8'h00, 16'hFFFF, 8'h00, r.qpn}, last: 1'b0, psn_chk: 1'b0, psn_after: 24'h0};
        exp_q.push_back(b);
        b = '{data: {8'h00, model_psn, 16'h0000, r.len}, last: (r.len == 16'd0), psn_chk: 1'b1,
              psn_after: model_psn + 24'd1};
        exp_q.push_back(b);
        model_psn = model_psn + 24'd1;
        for (int i = 0; i < int'(r.len); i++) begin
            if (dir_pl.size() > 0) w = dir_pl.pop_front();
            else w = {$urandom, $urandom};
            pl_q.push_back(w);
            b = '{data: w, last: (i == int'(r.len) - 1), psn_chk: 1'b0, psn_after: 24'h0};
            exp_q.push_back(b);
        end
    endtask

    initial begin : req_drv
        bit hs;
        req_t r;
        req_valid = 1'b0; req_opcode = '0; req_qpn = '0; req_len = '0;
        forever begin
            @(negedge clk);
            hs = req_valid && req_ready;
            if (hs) req_hs_cyc = cyc;
            @(posedge clk); #1;
            if (hs) begin
                req_valid  = 1'b0;
                req_opcode = 8'($urandom);
                req_qpn    = 24'($urandom);
                req_len    = 16'($urandom);
            end
            if (!req_valid && script.size() > 0) begin
                r = script.pop_front();
                gen(r);
                req_valid  = 1'b1;
                req_opcode = r.op;
                req_qpn    = r.qpn;
                req_len    = r.len;
            end
        end
    end

    initial begin : pl_drv
        bit hs;
        pl_valid = 1'b0; pl_data = '0;
        forever begin
            @(negedge clk);
            hs = pl_valid && pl_ready;
            @(posedge clk); #1;
            if (hs) begin
                pl_valid = 1'b0;
                if (pl_q.size() > 0) void'(pl_q.pop_front());
            end
            if (!pl_valid && pl_en && pl_q.size() > 0 && int'($urandom_range(99)) < pl_pct) begin
                pl_valid = 1'b1;
                pl_data  = pl_q[0];
            end
        end
    end

    initial begin : rdy_drv
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = rdy_mode ? ($urandom_range(2) != 0) : 1'b1;
        end
    end

    initial begin : mon
        bit          done_exp, stall_pend;
        logic [63:0] held_data;
        logic        held_last;
        beat_t       e;
        done_exp = 0; stall_pend = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp = 0; stall_pend = 0;
            end else begin
                chk("pkt_done", pkt_done, done_exp);
                done_exp = 0;
                if (pl_ready) pl_rdy_seen = 1;
                if (stall_pend) begin
                    chk("hold_valid", tx_valid, 1'b1);
                    chk("hold_data", tx_data, held_data);
                    chk("hold_last", tx_last, held_last);
                end
                stall_pend = 0;
                if (tx_valid && !tx_ready) begin
                    chk("pl_ready_stall", pl_ready, 1'b0);
                    chk("req_ready_stall", req_ready, 1'b0);
                    stall_pend = 1; held_data = tx_data; held_last = tx_last;
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", tx_data, 64'h0 - 64'h1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", tx_data, e.data);
                        chk("tx_last", tx_last, e.last);
                        if (e.psn_chk) chk("psn_cur", psn_cur, e.psn_after);
                        done_exp = e.last;
                    end
                    hs_cnt++;
                    if (hs_cnt == 1) first_hs = cyc;
                    last_hs = cyc;
                end
            end
        end
    end

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while ((script.size() != 0 || exp_q.size() != 0 || pl_q.size() != 0 || req_valid) && n < max_cyc) begin
            @(negedge clk); #2;
            n++;
        end
        chk(tag, (n < max_cyc), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int n;
        rst = 1'b1; rdy_mode = 0; pl_pct = 100; pl_en = 1; model_psn = PSN0;
        hs_cnt = 0; first_hs = 0; last_hs = 0; req_hs_cyc = 0; pl_rdy_seen = 0;
        #3;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 64'h0);
        chk("rst_tx_last", tx_last, 1'b0);
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_psn", psn_cur, PSN0);
        chk("rst_pl_ready", pl_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back across the PSN wrap: three 4-beat packets, no gaps allowed.
        hs_cnt = 0;
        for (int k = 0; k < 3; k++) script.push_back('{op: 8'h0A, qpn: 24'($urandom), len: 16'd2});
        wait_drain("b2b_drain", 200);
        chk("b2b_beats", hs_cnt, 12);
        chk("b2b_span", last_hs - first_hs + 1, 12);
        chk("b2b_psn", psn_cur, 24'h000001);

        // Single known packet and its request-to-beat0 latency.
        hs_cnt = 0;
        dir_pl.push_back(64'hAAAAAAAAAAAAAAAA);
        dir_pl.push_back(64'hBBBBBBBBBBBBBBBB);
        script.push_back('{op: 8'h04, qpn: 24'h000123, len: 16'd2});
        wait_drain("pkt1_drain", 200);
        chk("pkt1_latency", first_hs - req_hs_cyc, 1);
        chk("pkt1_beats", hs_cnt, 4);

        // Header-only packet must never open the payload port.
        pl_rdy_seen = 0;
        script.push_back('{op: 8'h0A, qpn: 24'hABCDEF, len: 16'd0});
        wait_drain("len0_drain", 200);
        chk("len0_pl_ready", pl_rdy_seen, 1'b0);

        // Random lengths with downstream stalls and payload bubbles.
        rdy_mode = 1; pl_pct = 60;
        for (int k = 0; k < 40; k++)
            script.push_back('{op: 8'($urandom), qpn: 24'($urandom), len: 16'($urandom_range(6))});
        wait_drain("rand_drain", 5000);

        // Reset in the middle of a len=4 packet, right after beat1 went out.
        rdy_mode = 0; pl_pct = 100; pl_en = 0;
        script.push_back('{op: 8'h0C, qpn: 24'h000777, len: 16'd4});
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (exp_q.size() != 4 && n < 50);
        chk("rst_mid_wait", (n < 50), 1'b1);
        rst = 1'b1; #1;
        chk("rst_mid_tx_valid", tx_valid, 1'b0);
        chk("rst_mid_tx_last", tx_last, 1'b0);
        chk("rst_mid_psn", psn_cur, PSN0);
        exp_q.delete(); pl_q.delete(); model_psn = PSN0;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_rel_req_ready", req_ready, 1'b1);
        pl_en = 1;
        script.push_back('{op: 8'h0D, qpn: 24'h000888, len: 16'd1});
        wait_drain("post_rst_drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
